// File: rtl/npu_uart_pkg.sv
// npu_uart_pkg: shared UART receiver types and constants (state enum, data width, minimum oversampling)
package npu_uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_CLKS_PER_BIT = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } uart_rx_state_t;
endpackage

// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial line in, received byte/strobes/busy out; master = receiver, slave = consumer (parity_err only with UART_RX_PARITY_EN)
interface uart_rx_byte_if;
  import npu_uart_pkg::*;
  logic rx;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic rx_done;
  logic frame_err;
  logic busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  modport master (input rx, output rx_data, rx_done, frame_err, busy, parity_err);
  modport slave (output rx, input rx_data, rx_done, frame_err, busy, parity_err);
`else
  modport master (input rx, output rx_data, rx_done, frame_err, busy);
  modport slave (output rx, input rx_data, rx_done, frame_err, busy);
`endif
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer; clk/rst (sync active-low) in, d async in, q synchronized out, RST_VAL reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver (8E1 with UART_RX_PARITY_EN); clk, rst (sync active-low), bus.master: rx in, rx_data/rx_done/frame_err/busy[/parity_err] out
module uart_rx_byte
  import npu_uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input logic clk,
  input logic rst,
  uart_rx_byte_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(UART_DATA_BITS - 1);
  if (CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) begin : g_cpb_check
    $error("uart_rx_byte: CLKS_PER_BIT too small");
  end
  uart_rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n, data, data_n;
  logic done, done_n, ferr, ferr_n, rx_s;
`ifdef UART_RX_PARITY_EN
  logic pbad, pbad_n, perr, perr_n;
  assign bus.parity_err = perr;
`else
  logic pbad;
  assign pbad = 1'b0;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx), .q(rx_s));
  assign bus.rx_data   = data;
  assign bus.rx_done   = done;
  assign bus.frame_err = ferr;
  assign bus.busy      = (state != S_IDLE);
  always_comb begin
    state_n = state;
    cnt_n   = (state == S_IDLE || state == S_WAIT_IDLE) ? '0 : cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n  = pbad;
    perr_n  = 1'b0;
`endif
    case (state)
      S_IDLE: if (!rx_s) state_n = S_START;
      S_START: if (cnt == HALF) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
        pbad_n  = 1'b0;
`endif
      end
      S_DATA: if (cnt == FULL) begin
        cnt_n   = '0;
        shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
        idx_n   = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_n = (idx == LAST) ? S_PARITY : S_DATA;
`else
        state_n = (idx == LAST) ? S_STOP : S_DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt == FULL) begin
        cnt_n   = '0;
        pbad_n  = rx_s != ^shift;
        state_n = S_STOP;
      end
`endif
      S_STOP: if (cnt == FULL) begin
        cnt_n   = '0;
        state_n = rx_s ? S_IDLE : S_WAIT_IDLE;
        ferr_n  = !rx_s;
        done_n  = rx_s && !pbad;
        data_n  = (rx_s && !pbad) ? shift : data;
`ifdef UART_RX_PARITY_EN
        perr_n  = rx_s && pbad;
`endif
      end
      S_WAIT_IDLE: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      done  <= 1'b0;
      ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad  <= 1'b0;
      perr  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      data  <= data_n;
      done  <= done_n;
      ferr  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      pbad  <= pbad_n;
      perr  <= perr_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed table-driven bench for uart_rx_byte at 10 clocks per bit
module tb_uart_rx_byte;
  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif
  localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB + NPB * CPB;
  localparam int FRAME = (10 + NPB) * CPB;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] done_q[$];
  int done_t[$];
  int nd, nf, np, t0;
  logic got;
  uart_rx_byte_if bus ();
  uart_rx_byte #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [2:0] flags;
  always @(negedge clk) begin
`ifdef UART_RX_PARITY_EN
    flags = {bus.rx_done, bus.frame_err, bus.parity_err};
    if (bus.parity_err) perr_cnt++;
`else
    flags = {bus.rx_done, bus.frame_err, 1'b0};
`endif
    if (bus.rx_done) begin
      done_q.push_back(bus.rx_data);
      done_t.push_back(cyc);
    end
    if (bus.frame_err) ferr_cnt++;
    if (flags != 3'b000) begin
      n_tests++;
      if ($countones(flags) > 1) begin
        n_fail++;
        $display("FAIL strobe_exclusive: flags %b, required at most one set", flags);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_good, input int gap);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par_good ? ^d : ~^d, CPB);
`else
    if (!par_good) $display("note: parity request ignored in 8N1 build");
`endif
    hold(stop_b, CPB);
    if (gap > 0) hold(1'b1, gap);
  endtask
  typedef struct {
    logic [7:0] d;
    logic       stop_b;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;
  vec_t v[6];
  initial begin
    v[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    v[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    v[2] = '{8'h11, 1'b1, 1, 0, 8'h11};
    v[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
    v[4] = '{8'h01, 1'b0, 0, 1, 8'h80};
    v[5] = '{8'h7E, 1'b1, 1, 0, 8'h7E};
    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rx_data", bus.rx_data, 8'h00);
    chk("reset_rx_done", bus.rx_done, 1'b0);
    chk("reset_frame_err", bus.frame_err, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    rst = 1'b1;
    hold(1'b1, 10);
    for (int i = 0; i < 6; i++) begin
      nd = done_q.size();
      nf = ferr_cnt;
      t0 = cyc;
      send_byte(v[i].d, v[i].stop_b, 1'b1, 0);
      if (!v[i].stop_b) begin
        hold(1'b0, 50);
        chk("break_busy", bus.busy, 1'b1);
      end
      hold(1'b1, 20);
      chk("vec_done_count", done_q.size() - nd, v[i].exp_done);
      chk("vec_ferr_count", ferr_cnt - nf, v[i].exp_ferr);
      chk("vec_rx_data", bus.rx_data, v[i].exp_data);
      chk("vec_busy_after", bus.busy, 1'b0);
      if (i == 0) chk("latency", (done_q.size() > nd) ? done_t[nd] - t0 : -1, LAT);
    end
    nd = done_q.size();
    hold(1'b0, 3);
    chk("false_start_busy_high", bus.busy, 1'b1);
    bus.rx = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk);
      #1;
      got = !bus.busy;
    end
    chk("false_start_busy_drop", got, 1'b1);
    hold(1'b1, 20);
    chk("false_start_no_done", done_q.size() - nd, 0);
    chk("false_start_rx_data", bus.rx_data, 8'h7E);
    nd = done_q.size();
    send_byte(8'h00, 1'b1, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 1'b1, 20);
    chk("b2b_count", done_q.size() - nd, 2);
    chk("b2b_first", (done_q.size() > nd) ? done_q[nd] : 8'h55, 8'h00);
    chk("b2b_second", (done_q.size() > nd + 1) ? done_q[nd+1] : 8'h55, 8'hFF);
    chk("b2b_spacing", (done_q.size() > nd + 1) ? done_t[nd+1] - done_t[nd] : -1, FRAME);
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(v[0].d[0] ^ (8'h5A >> i) & 1'b1 ^ v[0].d[0], CPB);
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_rx_data", bus.rx_data, 8'h00);
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_rx_done", bus.rx_done, 1'b0);
    chk("midreset_frame_err", bus.frame_err, 1'b0);
    rst = 1'b1;
    nd = done_q.size();
    nf = ferr_cnt;
    hold(1'b1, 30);
    chk("midreset_no_done", done_q.size() - nd, 0);
    send_byte(8'hC3, 1'b1, 1'b1, 20);
    chk("post_reset_done", done_q.size() - nd, 1);
    chk("post_reset_data", bus.rx_data, 8'hC3);
    chk("post_reset_no_ferr", ferr_cnt - nf, 0);
`ifdef UART_RX_PARITY_EN
    nd = done_q.size();
    np = perr_cnt;
    send_byte(8'h07, 1'b1, 1'b1, 20);
    chk("parity_ok_done", done_q.size() - nd, 1);
    chk("parity_ok_data", bus.rx_data, 8'h07);
    chk("parity_ok_no_perr", perr_cnt - np, 0);
    nd = done_q.size();
    send_byte(8'h07, 1'b1, 1'b0, 20);
    chk("parity_bad_perr", perr_cnt - np, 1);
    chk("parity_bad_no_done", done_q.size() - nd, 0);
    chk("parity_bad_data", bus.rx_data, 8'h07);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
